// File: rtl/decoder_pkg.sv
// Shared types and the binary-to-one-hot decode helper for the handshaked decoder.
package decoder_pkg;

    localparam int unsigned MAX_OUT = 256;

    typedef logic [1:0] buf_state_t;
    localparam buf_state_t ST_EMPTY = 2'd0;
    localparam buf_state_t ST_ONE   = 2'd1;
    localparam buf_state_t ST_FULL  = 2'd2;

    // Bit k is set iff code==k and k is a legal line; callers truncate to their width.
    function automatic logic [MAX_OUT-1:0] onehot_decode(input logic [31:0] code,
                                                         input int unsigned num_lines);
        logic [MAX_OUT-1:0] res;
        res = '0;
        for (int unsigned k = 0; k < MAX_OUT; k++) begin
            res[k] = (code == k) && (k < num_lines);
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry valid/ready buffer: main entry drives the outputs, skid entry absorbs one extra word.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             full_q, full_d;
    logic             live_q;
    logic             push, pop;

    // Ready depends only on registers and enable, never on out_ready.
    assign in_ready  = enable && live_q && !full_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            live_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                // Push and pop together reload main directly so the stream has no bubble.
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (pop) begin
                    main_d  = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        full_d      = (state_d == ST_FULL);
    end

endmodule

// File: rtl/decoder_hs.sv
// Binary-to-one-hot decoder with valid/ready on both sides; codes are decoded on capture.
module decoder_hs
    import decoder_pkg::*;
#(
    parameter int unsigned IN_SIZE   = 4,
    parameter int unsigned NUM_LINES = 1 << IN_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_SIZE-1:0]        in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1 << IN_SIZE)-1:0] out,
    output logic                      out_err
);

    localparam int unsigned OUT_SIZE = 1 << IN_SIZE;
    localparam int unsigned PW       = OUT_SIZE + 1;

    logic [OUT_SIZE-1:0] dec;
    logic                err;
    logic [PW-1:0]       payload;
    logic [PW-1:0]       entry;

    // Stored pre-decoded so the output register path carries no decode logic.
    always_comb begin
        dec     = OUT_SIZE'(onehot_decode(32'(in), NUM_LINES));
        err     = (32'(in) >= NUM_LINES);
        payload = {err, dec};
    end

    decoder_skid_buf #(
        .WIDTH(PW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (entry)
    );

    assign out     = entry[OUT_SIZE-1:0];
    assign out_err = entry[OUT_SIZE];

endmodule

// File: doc/decoder_hs.md
Name: decoder_hs

Overview:
- Binary-to-one-hot decoder with valid/ready handshakes on both sides and a 2-entry skid buffer.
- It is the companion to the team's one-hot-to-binary encoder: it takes a binary code and drives exactly one line of a one-hot bus.
- Sits between a code producer (arbiter index, address field) and a select consumer that may apply backpressure.
- Output path is fully registered, so the block can break timing paths in wide select fabrics.

Parameters:
- IN_SIZE, 4, width of the binary input code.
- OUT_SIZE, 1<<IN_SIZE, width of the one-hot output. Derived; must not be overridden.
- NUM_LINES, OUT_SIZE, number of legal codes (1..OUT_SIZE). A code >= NUM_LINES is out of range.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, no new codes are accepted; the output side keeps draining.
- in_valid  input  1  input code valid.
- in_ready  output  1  block can accept a code this cycle.
- in  input  IN_SIZE  binary code.
- out_valid  output  1  out/out_err hold a decoded entry.
- out_ready  input  1  consumer accepts the entry this cycle.
- out  output  OUT_SIZE  one-hot decode; all zero for an out-of-range code.
- out_err  output  1  entry came from a code >= NUM_LINES.

Behaviour:
- Reset (asserted asynchronously): out_valid=0, out='0, out_err=0, in_ready=0. Both buffer entries are empty.
- First clk edge after rst_n deassertion: in_ready follows the normal rule.
- Input handshake: accepted when in_valid && in_ready at a clk edge. Output handshake: consumed when out_valid && out_ready.
- Decode rule: out[k]=1 iff in==k and k<NUM_LINES. Exactly one bit is set for legal codes. out_err=(in>=NUM_LINES).
- Decode happens combinationally at entry capture and is stored pre-decoded; no decode logic sits on the output register path.
- Latency: an accepted code appears on out/out_valid in the next cycle when the buffer was empty. Throughput is 1 code per cycle with out_ready held high.
- Storage: main entry (drives outputs) plus skid entry.
- in_ready = enable && !skid_full. It is a function of registers plus enable only, with no combinational path from out_ready.
- Buffer states (FSM):
  - EMPTY: accept -> load main -> ONE.
  - ONE: accept && pop -> main reloaded, stay ONE. Accept only -> load skid -> FULL. Pop only -> EMPTY.
  - FULL (in_ready=0): pop -> skid moves to main -> ONE.
- Simultaneous accept and pop in ONE is a pass-through; no bubble is allowed.
- Ordering: strict FIFO. No entry may be dropped or duplicated.
- out/out_err are stable while out_valid && !out_ready.
- out/out_err are don't-care when out_valid=0, but the RTL drives '0.
- enable low: in_ready=0 the same cycle. Pending entries still drain. Toggling enable never corrupts stored entries.
- in changing while in_valid=0 has no effect.
- Reset mid-operation: all entries are discarded immediately and the outputs go to reset values.
- NUM_LINES=OUT_SIZE: out_err is constant 0 and may be optimized away.
- Assertions (bench):
  - $onehot(out) when out_valid && !out_err.
  - out=='0 when out_err.
  - No acceptance while in_ready=0.

Decomposition:
- decoder_pkg:
  - function onehot_decode (IN_SIZE -> OUT_SIZE, NUM_LINES-bounded).
  - typedef for the buffer state enum {EMPTY, ONE, FULL}.
- One sub-module, decoder_skid_buf: the 2-entry valid/ready buffer, parameterized on payload width.
- decoder_hs = decode function + decoder_skid_buf instance with payload width OUT_SIZE+1.

Test Plan:
- Reset then stream in=0..15 with in_valid=1, out_ready=1, enable=1 (IN_SIZE=4) -> out=16'h0001,16'h0002,...,16'h8000 on consecutive cycles, first one 1 cycle after acceptance, no bubbles.
- NUM_LINES=10: send in=9, in=10, in=15 -> out=16'h0200 err=0; out=16'h0000 err=1; out=16'h0000 err=1.
- out_ready=0 and send in=3,5,7 -> first two accepted (0x0008, 0x0020), in_ready=0 after the second. Raise out_ready -> out 0x0008, 0x0020, then 0x0080 accepted and delivered in order.
- enable=0 with in_valid=1, in=2 and one entry pending (in=6) -> in_ready=0, out=0x0040 still drains. After enable=1, out=0x0004 appears.
- Assert rst_n=0 asynchronously mid-stream while FULL -> out_valid, out, out_err go to 0 without a clock edge. After release, stale entries are never emitted.
- Randomized out_ready/in_valid, 1000 codes -> scoreboard matches in order, $onehot holds, no loss or duplication.
